// File: rtl/core_wb_pkg.sv
// rtl/core_wb_pkg.sv - shared encodings and lane helpers for the core-to-Wishbone initiator
package core_wb_pkg;

  localparam logic [2:0] OPT_B  = 3'b000;
  localparam logic [2:0] OPT_H  = 3'b001;
  localparam logic [2:0] OPT_W  = 3'b010;
  localparam logic [2:0] OPT_BU = 3'b100;
  localparam logic [2:0] OPT_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_MERGE  = 3'd3,
    S_WR     = 3'd4,
    S_RESP   = 3'd5
  } wb_init_state_t;

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] sel);
    return word[{sel, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] half_lane(input logic [31:0] word, input logic sel);
    return word[{sel, 4'b0000} +: 16];
  endfunction

  function automatic logic opt_legal(input logic [2:0] opt);
    return (opt == OPT_B) || (opt == OPT_H) || (opt == OPT_W) ||
           (opt == OPT_BU) || (opt == OPT_HU);
  endfunction

  function automatic logic opt_misaligned(input logic [2:0] opt, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    if ((opt == OPT_H) || (opt == OPT_HU)) r = addr_lo[0];
    else if (opt == OPT_W)                 r = (addr_lo != 2'b00);
    return r;
  endfunction

  function automatic logic opt_is_word(input logic [2:0] opt);
    return opt == OPT_W;
  endfunction

endpackage

// File: rtl/wb_lane_unit.sv
// rtl/wb_lane_unit.sv - combinational load extract/extend and sub-word store merge
module wb_lane_unit
  import core_wb_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_opt,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = byte_lane(i_word, i_addr_lo);
  assign w_half = half_lane(i_word, i_addr_lo[1]);

  always_comb begin
    o_load = i_word;
    case (i_opt)
      OPT_B:   o_load = {{24{w_byte[7]}}, w_byte};
      OPT_BU:  o_load = {24'h000000, w_byte};
      OPT_H:   o_load = {{16{w_half[15]}}, w_half};
      OPT_HU:  o_load = {16'h0000, w_half};
      default: o_load = i_word;
    endcase
  end

  // Store size is taken from the width field only; BU/HU stores behave as B/H.
  always_comb begin
    o_merged = i_word;
    case (i_opt)
      OPT_B, OPT_BU: o_merged[{i_addr_lo, 3'b000} +: 8]      = i_wdata[7:0];
      OPT_H, OPT_HU: o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default:       o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/core_wb_initiator.sv
// rtl/core_wb_initiator.sv - native load/store port to Wishbone classic initiator
// Sub-word stores run as read-modify-write since the responder has no byte selects.
module core_wb_initiator
  import core_wb_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  option,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        memory_response,
  output logic        error,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  wb_init_state_t r_state, w_state_next;

  logic        r_cyc, r_stb, r_we, r_resp, r_err;
  logic [31:0] r_adr, r_dat_o, r_rdata;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_opt;
  logic [31:0] r_wdata, r_word, r_tmo_cnt;

  logic        w_cyc_next, w_stb_next, w_we_next, w_resp_next, w_err_next;
  logic [31:0] w_adr_next, w_dat_o_next, w_rdata_next;
  logic [1:0]  w_addr_lo_next;
  logic [2:0]  w_opt_next;
  logic [31:0] w_wdata_next, w_word_next, w_tmo_next;

  logic        w_ack, w_tmo_hit, w_req, w_reject;
  logic [31:0] w_lane_word, w_load_data, w_merged;

  assign w_ack     = wb_ack_i & r_stb;
  assign w_tmo_hit = TMO_EN && (r_tmo_cnt == TMO_LAST);
  assign w_req     = memory_read | memory_write;
  assign w_reject  = (memory_read & memory_write) | ~opt_legal(option) |
                     opt_misaligned(option, address[1:0]);

  // Loads extract straight from the bus; the merge works on the word captured in RMW_RD.
  assign w_lane_word = (r_state == S_MERGE) ? r_word : wb_dat_i;

  wb_lane_unit u_lane (
    .i_word    (w_lane_word),
    .i_addr_lo (r_addr_lo),
    .i_opt     (r_opt),
    .i_wdata   (r_wdata),
    .o_load    (w_load_data),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_resp    <= 1'b0;
      r_err     <= 1'b0;
      r_adr     <= BOOT_ADDRESS;
      r_dat_o   <= 32'h0;
      r_rdata   <= 32'h0;
      r_addr_lo <= 2'b00;
      r_opt     <= OPT_W;
      r_wdata   <= 32'h0;
      r_word    <= 32'h0;
      r_tmo_cnt <= 32'h0;
    end else begin
      r_state   <= w_state_next;
      r_cyc     <= w_cyc_next;
      r_stb     <= w_stb_next;
      r_we      <= w_we_next;
      r_resp    <= w_resp_next;
      r_err     <= w_err_next;
      r_adr     <= w_adr_next;
      r_dat_o   <= w_dat_o_next;
      r_rdata   <= w_rdata_next;
      r_addr_lo <= w_addr_lo_next;
      r_opt     <= w_opt_next;
      r_wdata   <= w_wdata_next;
      r_word    <= w_word_next;
      r_tmo_cnt <= w_tmo_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cyc_next     = r_cyc;
    w_stb_next     = r_stb;
    w_we_next      = r_we;
    w_resp_next    = r_resp;
    w_err_next     = r_err;
    w_adr_next     = r_adr;
    w_dat_o_next   = r_dat_o;
    w_rdata_next   = r_rdata;
    w_addr_lo_next = r_addr_lo;
    w_opt_next     = r_opt;
    w_wdata_next   = r_wdata;
    w_word_next    = r_word;
    w_tmo_next     = r_tmo_cnt;

    unique case (r_state)
      S_IDLE: begin
        w_tmo_next = 32'h0;
        if (w_req) begin
          w_addr_lo_next = address[1:0];
          w_opt_next     = option;
          w_wdata_next   = write_data;
          if (w_reject) begin
            w_state_next = S_RESP;
            w_resp_next  = 1'b1;
            w_err_next   = 1'b1;
          end else begin
            w_adr_next = {address[31:2], 2'b00};
            w_cyc_next = 1'b1;
            w_stb_next = 1'b1;
            if (memory_read) begin
              w_state_next = S_RD;
              w_we_next    = 1'b0;
            end else if (opt_is_word(option)) begin
              w_state_next = S_WR;
              w_we_next    = 1'b1;
              w_dat_o_next = write_data;
            end else begin
              w_state_next = S_RMW_RD;
              w_we_next    = 1'b0;
            end
          end
        end
      end

      S_RD, S_RMW_RD, S_WR: begin
        if (w_ack) begin
          w_tmo_next = 32'h0;
          w_stb_next = 1'b0;
          if (r_state == S_RMW_RD) begin
            w_word_next  = wb_dat_i;
            w_state_next = S_MERGE;
          end else begin
            w_cyc_next   = 1'b0;
            w_we_next    = 1'b0;
            w_resp_next  = 1'b1;
            w_err_next   = 1'b0;
            w_state_next = S_RESP;
            if (r_state == S_RD) w_rdata_next = w_load_data;
          end
        end else if (w_tmo_hit) begin
          // Abort the whole access, including a half-done RMW.
          w_tmo_next   = 32'h0;
          w_cyc_next   = 1'b0;
          w_stb_next   = 1'b0;
          w_we_next    = 1'b0;
          w_resp_next  = 1'b1;
          w_err_next   = 1'b1;
          w_state_next = S_RESP;
        end else if (TMO_EN) begin
          w_tmo_next = r_tmo_cnt + 32'd1;
        end
      end

      S_MERGE: begin
        w_dat_o_next = w_merged;
        w_stb_next   = 1'b1;
        w_we_next    = 1'b1;
        w_state_next = S_WR;
      end

      S_RESP: begin
        w_resp_next  = 1'b0;
        w_err_next   = 1'b0;
        w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign read_data       = r_rdata;
  assign memory_response = r_resp;
  assign error           = r_err;
  assign wb_cyc_o        = r_cyc;
  assign wb_stb_o        = r_stb;
  assign wb_we_o         = r_we;
  assign wb_adr_o        = r_adr;
  assign wb_dat_o        = r_dat_o;

endmodule

// File: tb/tb_core_wb_initiator.sv
// tb/tb_core_wb_initiator.sv - scoreboard bench for core_wb_initiator
module tb_core_wb_initiator;
  import core_wb_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memory_read = 1'b0, memory_write = 1'b0;
  logic [2:0]  option = 3'b000;
  logic [31:0] address = 32'h0, write_data = 32'h0;
  logic [31:0] read_data;
  logic        memory_response, error;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;

  core_wb_initiator #(.BOOT_ADDRESS(BOOT), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .memory_read(memory_read), .memory_write(memory_write),
    .option(option), .address(address), .write_data(write_data),
    .read_data(read_data), .memory_response(memory_response), .error(error),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          t0;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          stb_n;
    int          gap_n;
  } exp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  int n_tests = 0, n_fail = 0;
  int cycle = 0;
  int stb_n = 0, gap_n = 0;

  logic [31:0] mem_word = 32'h0;
  int          resp_wait = 0;
  int          resp_mode = 0;
  logic        manual_ack = 1'b0;
  int          wcnt = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Responder model: acks after resp_wait strobe cycles, checks writes against wr_q.
  always @(posedge clk) begin
    #2;
    if (resp_mode == 1) begin
      wb_ack_i = manual_ack;
      wb_dat_i = 32'hBAD0_BAD0;
      wcnt     = 0;
    end else if (wb_stb_o) begin
      if (wcnt >= resp_wait) begin
        wb_ack_i = 1'b1;
        wb_dat_i = mem_word;
        wcnt     = 0;
        if (wb_we_o) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write", wb_adr_o, 32'hFFFF_FFFF);
          end else begin
            wr_t w;
            w = wr_q.pop_front();
            chk("write_adr", wb_adr_o, w.adr);
            chk("write_dat", wb_dat_o, w.dat);
          end
          mem_word = wb_dat_o;
        end
      end else begin
        wb_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      wb_ack_i = 1'b0;
      wcnt     = 0;
    end
  end

  // Monitor: count bus activity and compare each response with the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (wb_stb_o) stb_n++;
    if (wb_cyc_o && !wb_stb_o) gap_n++;
    if (memory_response) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {31'h0, memory_response}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("t%0d_rdata", e.id), read_data, e.rdata);
        chk($sformatf("t%0d_error", e.id), {31'h0, error}, {31'h0, e.err});
        chk($sformatf("t%0d_latency", e.id), 32'(cycle - e.t0), 32'(e.lat));
        chk($sformatf("t%0d_stb_cycles", e.id), 32'(stb_n), 32'(e.stb_n));
        chk($sformatf("t%0d_merge_gap", e.id), 32'(gap_n), 32'(e.gap_n));
      end
      stb_n = 0;
      gap_n = 0;
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL resp_wait: got no memory_response within 60 cycles, expected one");
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input int id, input logic rd, input logic wr, input logic [2:0] opt,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input int sn, input int gn);
    exp_t e;
    @(negedge clk);
    memory_read  = rd;
    memory_write = wr;
    option       = opt;
    address      = adr;
    write_data   = wd;
    e.id = id; e.t0 = cycle; e.rdata = exp_rd; e.err = exp_err;
    e.lat = lat; e.stb_n = sn; e.gap_n = gn;
    exp_q.push_back(e);
    @(negedge clk);
    memory_read  = 1'b0;
    memory_write = 1'b0;
    option       = 3'b111;
    address      = 32'hFFFF_FFFF;
    write_data   = 32'h0;
    wait_done();
  endtask

  function automatic void push_wr(input logic [31:0] adr, input logic [31:0] dat);
    wr_t w;
    w.adr = adr;
    w.dat = dat;
    wr_q.push_back(w);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, wb_stb_o}, 32'h0);
    chk("rst_we", {31'h0, wb_we_o}, 32'h0);
    chk("rst_resp", {31'h0, memory_response}, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_dat_o", wb_dat_o, 32'h0);
    chk("rst_adr", wb_adr_o, BOOT);
    rst = 1'b0;

    mem_word = 32'hDEAD_BEEF;
    issue(1, 1, 0, OPT_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 2, 1, 0);
    mem_word = 32'h80FF_1234;
    issue(2, 1, 0, OPT_B,  32'h103, 32'h0, 32'hFFFF_FF80, 0, 2, 1, 0);
    issue(3, 1, 0, OPT_BU, 32'h103, 32'h0, 32'h0000_0080, 0, 2, 1, 0);
    issue(4, 1, 0, OPT_H,  32'h102, 32'h0, 32'hFFFF_80FF, 0, 2, 1, 0);
    issue(5, 1, 0, OPT_HU, 32'h100, 32'h0, 32'h0000_1234, 0, 2, 1, 0);
    issue(6, 1, 0, OPT_B,  32'h101, 32'h0, 32'h0000_0012, 0, 2, 1, 0);
    mem_word = 32'hCAFE_F00D; resp_wait = 2;
    issue(7, 1, 0, OPT_W, 32'h200, 32'h0, 32'hCAFE_F00D, 0, 4, 3, 0);
    resp_wait = 0;

    mem_word = 32'h1122_3344; push_wr(32'h100, 32'h11AA_3344);
    issue(8, 0, 1, OPT_B, 32'h102, 32'hFFFF_FFAA, 32'hCAFE_F00D, 0, 4, 2, 1);
    mem_word = 32'h1122_3344; push_wr(32'h100, 32'hBEEF_3344);
    issue(9, 0, 1, OPT_H, 32'h102, 32'h1234_BEEF, 32'hCAFE_F00D, 0, 4, 2, 1);
    mem_word = 32'h1122_3344; push_wr(32'h100, 32'h1122_5A44); resp_wait = 1;
    issue(10, 0, 1, OPT_B, 32'h101, 32'h0000_005A, 32'hCAFE_F00D, 0, 6, 4, 1);
    resp_wait = 0; push_wr(32'h104, 32'h5555_AAAA);
    issue(11, 0, 1, OPT_W, 32'h104, 32'h5555_AAAA, 32'hCAFE_F00D, 0, 2, 1, 0);

    issue(12, 1, 0, OPT_H, 32'h101, 32'h0, 32'hCAFE_F00D, 1, 1, 0, 0);
    issue(13, 1, 0, OPT_W, 32'h102, 32'h0, 32'hCAFE_F00D, 1, 1, 0, 0);
    issue(14, 1, 0, 3'b011, 32'h100, 32'h0, 32'hCAFE_F00D, 1, 1, 0, 0);
    issue(15, 1, 1, OPT_W, 32'h100, 32'h0, 32'hCAFE_F00D, 1, 1, 0, 0);
    issue(16, 0, 1, OPT_H, 32'h101, 32'h0, 32'hCAFE_F00D, 1, 1, 0, 0);

    resp_mode = 1;
    issue(17, 1, 0, OPT_W, 32'h300, 32'h0, 32'hCAFE_F00D, 1, 9, 8, 0);
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_ack_read_data", read_data, 32'hCAFE_F00D);
    chk("stray_ack_cyc", {31'h0, wb_cyc_o}, 32'h0);
    resp_mode = 0;

    resp_wait = 5;
    @(negedge clk);
    memory_write = 1'b1; option = OPT_W; address = 32'h400; write_data = 32'h7777_7777;
    @(negedge clk);
    memory_write = 1'b0;
    n = 0;
    while (!wb_we_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_we_seen", {31'h0, wb_we_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_cyc", {31'h0, wb_cyc_o}, 32'h0);
    chk("rst_mid_stb", {31'h0, wb_stb_o}, 32'h0);
    chk("rst_mid_we", {31'h0, wb_we_o}, 32'h0);
    chk("rst_mid_resp", {31'h0, memory_response}, 32'h0);
    chk("rst_mid_read_data", read_data, 32'h0);
    repeat (6) @(negedge clk);
    stb_n = 0; gap_n = 0; resp_wait = 0;

    mem_word = 32'h0102_0304;
    issue(18, 1, 0, OPT_W, 32'h100, 32'h0, 32'h0102_0304, 0, 2, 1, 0);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_wb_initiator.md
# core_wb_initiator

Bus initiator between the RISC-V core's native memory port and the Wishbone classic responder port of the Controller (`core_cyc_i` … `core_ack_o`).
- Latches one native load/store request and runs the matching Wishbone cycle.
- Performs byte/halfword load extraction and sign/zero extension.
- The responder port has no byte selects, so sub-word stores are done as a read-modify-write (RMW) sequence.
- Returns a one-cycle response pulse to the core, with a bus timeout and a misalignment error.

## Interface
Parameters:
- `BOOT_ADDRESS`, 32'h00000000: reset value of the `wb_adr_o` register.
- `TIMEOUT_CYCLES`, 1024: cycles with `wb_stb_o` high and no `wb_ack_i` before abort; 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `memory_read` in 1: load request.
- `memory_write` in 1: store request.
- `option` in 3: access size, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `address` in 32: byte address.
- `write_data` in 32: store data, right-aligned.
- `read_data` out 32: extended load data.
- `memory_response` out 1: one-cycle completion pulse.
- `error` out 1: valid with `memory_response`; 1 = misaligned, illegal option, or timeout.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone cycle, strobe and write enable.
- `wb_adr_o` out 32: word-aligned address (bits [1:0] = 0).
- `wb_dat_o` out 32: write data.
- `wb_dat_i` in 32: read data.
- `wb_ack_i` in 1: acknowledge.

## Operation
- All outputs are registered. Reset values:
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `memory_response`, `error` = 0.
  - `read_data`, `wb_dat_o` = 0.
  - `wb_adr_o` = `BOOT_ADDRESS`.
  - State = IDLE; timeout counter = 0.
- States: IDLE, RD, RMW_RD, MERGE, WR, RESP.
- IDLE: request accepted on the first cycle `memory_read` or `memory_write` is high. `address`, `option` and `write_data` are latched that cycle; the core need not hold them.
  - Both `memory_read` and `memory_write` high, an illegal option, a misaligned H (addr[0]=1) or a misaligned W (addr[1:0]≠0) → RESP with `error`=1; no bus cycle.
  - Load → RD.
  - Word store → WR.
  - B or H store → RMW_RD.
- RD / RMW_RD:
  - `cyc`=`stb`=1, `we`=0.
  - On `wb_ack_i`: capture `wb_dat_i`.
  - RD then goes to RESP. For a load, `read_data` = lane selected by addr[1:0] (B) or addr[1] (H), sign- or zero-extended per `option`; W passes through.
  - RMW_RD then goes to MERGE.
- MERGE:
  - `stb`=0, `cyc` stays 1.
  - Store byte or halfword is inserted into the captured word at the addressed lane.
  - Next state is WR.
- WR:
  - `cyc`=`stb`=`we`=1, `wb_dat_o` = merged word (or `write_data` for a word store).
  - On ack → RESP.
- RESP:
  - `cyc`=`stb`=`we`=0, `memory_response`=1 for exactly one cycle, then IDLE.
  - `read_data` holds until the next load completes; stores do not modify it.
- Timeout:
  - Counter increments every cycle `stb`=1 without ack, and clears on ack and in IDLE.
  - At count `TIMEOUT_CYCLES`-1 without ack: drop `cyc`/`stb` and go to RESP with `error`=1, `read_data` unchanged.
  - During RMW, a timeout on either phase aborts the whole access.
- `wb_ack_i` is ignored when `wb_stb_o`=0, including late acks after a timeout.
- New requests arriving during RD/RMW_RD/MERGE/WR/RESP are ignored. The core issues one request and waits for `memory_response`.
- `rst` mid-transaction: next cycle all outputs are at reset values, no response is issued, and the in-flight access is dropped.

## Timing
- Request seen in IDLE at cycle 0.
- Load, or word store, with ack in cycle 1 (zero-wait responder): `cyc`/`stb` high in cycle 1, `memory_response` in cycle 2. Latency = 2 + wait states.
- Sub-word store, zero-wait:
  - RMW_RD in cycle 1.
  - MERGE in cycle 2 (`stb` low, `cyc` high).
  - WR in cycle 3.
  - Response in cycle 4.
- Error without bus cycle: response in cycle 1.
- `stb` drops in the cycle after the ack is sampled; no back-to-back strobes inside one access.
- Earliest next request acceptance: the cycle after RESP.

## Structure
- Package `core_wb_pkg`:
  - Option encodings (`OPT_B`, `OPT_H`, `OPT_W`, `OPT_BU`, `OPT_HU`).
  - State enum `wb_init_state_t`.
  - Lane-select helper functions.
- One natural sub-module: `wb_lane_unit`, purely combinational. It does load extract/extend and store merge from (word, addr[1:0], option, wdata).
- FSM, latches and timeout counter live in `core_wb_initiator`.

## Test plan
- LW at 0x100, responder returns 0xDEADBEEF with ack in cycle 1 → `memory_response` in cycle 2, `read_data`=0xDEADBEEF, `error`=0.
- LB at 0x103 with word 0x80FF_1234 → `read_data`=0xFFFFFF80; LBU at the same address → 0x00000080.
- SB 0xAA at 0x102 over memory word 0x11223344 → a read cycle, then one cycle with `stb`=0 and `cyc`=1, then a write of 0x11AA3344 with `wb_adr_o`=0x100; response in cycle 4.
- LH at 0x101 → response in cycle 1 with `error`=1; `wb_cyc_o` never asserted.
- With `TIMEOUT_CYCLES`=8, a responder that never acks → `stb` high for exactly 8 cycles, then `error`=1 response. A stray ack 2 cycles later is ignored and `read_data` is unchanged.
- `rst` asserted during the WR phase → next cycle `cyc`/`stb`/`we`=0, no `memory_response`. A following LW completes normally.
